cdu_incr_tx: RTL

//  Transmit side of the CDU angle-increment interface. Accepts single-cycle
//  +1/-1 angle-change requests from the read-counter logic and nets them in a

---
 rtl/cdu_incr_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cdu_incr_tx.sv
// cdu_incr_tx - transmit side of the CDU angle-increment interface.
//
// Single-cycle +1/-1 requests (up/dn) are netted into a signed pending
// counter. The counter is drained toward the AGC one increment per pulse on
// pcdu (positive) or mcdu (negative). Each pulse is PW cycles high and is
// followed by at least GAP low cycles.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   rst_n    in   synchronous active-low reset
//   up       in   +1 increment request
//   dn       in   -1 increment request
//   ovf_clr  in   clears the sticky overflow flag
//   pcdu     out  plus-increment pulse
//   mcdu     out  minus-increment pulse
//   pending  out  signed net increments not yet sent (CW bits)
//   busy     out  high while a pulse or its trailing gap is in progress
//   ovf      out  sticky: a request was dropped at saturation
module cdu_incr_tx #(
    parameter int CW  = 6,
    parameter int PW  = 2,
    parameter int GAP = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up,
    input  logic                 dn,
    input  logic                 ovf_clr,
    output logic                 pcdu,
    output logic                 mcdu,
    output logic signed [CW-1:0] pending,
    output logic                 busy,
    output logic                 ovf
);

    localparam int TMAX = (PW > GAP) ? PW : GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic signed [CW+1:0] ONE  = (CW+2)'(1);
    localparam logic signed [CW+1:0] PMAX = (CW+2)'((2 ** (CW - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [TW-1:0]          r_timer;
    logic                   r_pcdu;
    logic                   r_mcdu;
    logic                   r_busy;
    logic                   r_ovf;
    logic signed [CW-1:0]   r_pend;

    state_t                 w_state_n;
    logic [TW-1:0]          w_timer_n;
    logic                   w_pcdu_n;
    logic                   w_mcdu_n;
    logic                   w_busy_n;
    logic                   w_ovf_n;
    logic signed [CW-1:0]   w_pend_n;

    logic                   w_start;
    logic                   w_neg;
    logic signed [CW+1:0]   w_pend_ext;
    logic signed [CW+1:0]   w_inc;
    logic signed [CW+1:0]   w_dec;
    logic signed [CW+1:0]   w_sdir;
    logic signed [CW+1:0]   w_nxt;
    logic signed [CW+1:0]   w_keep;
    logic                   w_sat;

    // Net update: arithmetic is done two bits wider so the saturation test
    // can see values just outside the representable range.
    always_comb begin
        w_start    = (r_state == S_IDLE) && (r_pend != '0);
        w_neg      = r_pend[CW-1];
        w_pend_ext = {{2{r_pend[CW-1]}}, r_pend};
        w_inc      = up ? ONE : '0;
        w_dec      = dn ? ONE : '0;
        w_sdir     = '0;
        if (w_start) begin
            w_sdir = w_neg ? -ONE : ONE;
        end
        w_nxt  = w_pend_ext + w_inc - w_dec - w_sdir;
        w_keep = w_pend_ext - w_sdir;
        w_sat  = (w_nxt > PMAX) || (w_nxt < -PMAX);
        if (w_sat) begin
            w_pend_n = w_keep[CW-1:0];
            w_ovf_n  = 1'b1;
        end else begin
            w_pend_n = w_nxt[CW-1:0];
            w_ovf_n  = ovf_clr ? 1'b0 : r_ovf;
        end
    end

    // Pulse sequencer. The line chosen on IDLE->PULSE is simply held, so the
    // direction stays frozen for the whole pulse without a separate register.
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_pcdu_n  = r_pcdu;
        w_mcdu_n  = r_mcdu;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_n = S_PULSE;
                    w_timer_n = TW'(PW - 1);
                    w_pcdu_n  = !w_neg;
                    w_mcdu_n  = w_neg;
                end
            end
            S_PULSE: begin
                if (r_timer == '0) begin
                    w_state_n = S_GAP;
                    w_timer_n = TW'(GAP - 1);
                    w_pcdu_n  = 1'b0;
                    w_mcdu_n  = 1'b0;
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_timer_n = '0;
                w_pcdu_n  = 1'b0;
                w_mcdu_n  = 1'b0;
            end
        endcase
        w_busy_n = (w_state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_pcdu  <= 1'b0;
            r_mcdu  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_pcdu  <= w_pcdu_n;
            r_mcdu  <= w_mcdu_n;
            r_busy  <= w_busy_n;
            r_ovf   <= w_ovf_n;
            r_pend  <= w_pend_n;
        end
    end

    assign pcdu    = r_pcdu;
    assign mcdu    = r_mcdu;
    assign busy    = r_busy;
    assign ovf     = r_ovf;
    assign pending = r_pend;

endmodule
